// File: rtl/aes_trace_sequencer.sv
// Trace-campaign sequencer for AES_top: issues NUM_TRACES encryptions under a
// fixed key, each in an AES_en window plus idle gap, and returns tagged ciphertexts.
module aes_trace_sequencer #(
    parameter int           NUM_TRACES = 200,
    parameter int           EN_CYCLES  = 51,
    parameter int           GAP_CYCLES = 15,
    parameter logic [127:0] LFSR_SEED  = 128'h000000c8_00000000_00000000_00000000,
    parameter int           IDX_W      = 16
) (
    input  logic             AES_clk,
    input  logic             AES_rst,
    input  logic             start,
    input  logic             mode,
    input  logic [127:0]     fixed_pt,
    input  logic [127:0]     key_in,
    output logic             AES_en,
    output logic [127:0]     AES_data_in,
    output logic [127:0]     AES_key_in,
    input  logic [127:0]     AES_data_out,
    input  logic             AES_data_out_valid,
    output logic             trig,
    output logic             res_valid,
    output logic [127:0]     res_data,
    output logic [IDX_W-1:0] res_idx,
    output logic             res_fixed,
    output logic             busy,
    output logic             done,
    output logic             timeout_err
);

    localparam int CNT_MAX = (EN_CYCLES > GAP_CYCLES) ? EN_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, GAP, DONE} state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   idx;
    logic               mode_r;
    logic [127:0]       fixed_r;
    logic [127:0]       lfsr;
    logic [127:0]       lfsr_next;
    logic               captured;
    logic               run_end;
    logic               gap_end;
    logic               last_trace;
    logic               use_fixed;
    logic               take;

    // Galois step for x^128 + x^7 + x^2 + x + 1
    assign lfsr_next  = {lfsr[126:0], 1'b0} ^ ({128{lfsr[127]}} & 128'h87);

    assign run_end    = (state == RUN) && (cnt == CNT_W'(EN_CYCLES - 1));
    assign gap_end    = (state == GAP) && (cnt == CNT_W'(GAP_CYCLES - 1));
    assign last_trace = (idx == IDX_W'(NUM_TRACES - 1));
    assign use_fixed  = mode_r & ~idx[0];
    // First valid in the RUN+GAP window wins; later strobes are dropped
    assign take       = ((state == RUN) || (state == GAP)) && AES_data_out_valid && !captured;

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // AES_en/trig are decoded from the state register so reset drops them at once
    always_comb begin
        state_nxt = state;
        AES_en    = 1'b0;
        trig      = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: begin
                busy      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                busy   = 1'b1;
                AES_en = 1'b1;
                trig   = (cnt == '0);
                if (run_end) state_nxt = GAP;
            end
            GAP: begin
                busy = 1'b1;
                if (gap_end) state_nxt = last_trace ? DONE : LOAD;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            cnt         <= '0;
            idx         <= '0;
            mode_r      <= 1'b0;
            fixed_r     <= '0;
            lfsr        <= LFSR_SEED;
            captured    <= 1'b0;
            AES_data_in <= '0;
            AES_key_in  <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_idx     <= '0;
            res_fixed   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mode_r      <= mode;
                        fixed_r     <= fixed_pt;
                        AES_key_in  <= key_in;
                        timeout_err <= 1'b0;
                        idx         <= '0;
                        lfsr        <= LFSR_SEED;
                    end
                end
                LOAD: begin
                    AES_data_in <= use_fixed ? fixed_r : lfsr;
                    if (!use_fixed) lfsr <= lfsr_next;
                    cnt         <= '0;
                    captured    <= 1'b0;
                end
                RUN: cnt <= run_end ? '0 : cnt + CNT_W'(1);
                GAP: begin
                    cnt <= cnt + CNT_W'(1);
                    if (gap_end) begin
                        cnt <= '0;
                        if (!captured && !take) timeout_err <= 1'b1;
                        if (!last_trace) idx <= idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
            if (take) begin
                captured  <= 1'b1;
                res_valid <= 1'b1;
                res_data  <= AES_data_out;
                res_idx   <= idx;
                res_fixed <= use_fixed;
            end
        end
    end

endmodule

// File: tb/tb_aes_trace_sequencer.sv
// Bench for aes_trace_sequencer: AES stub (data^key after a per-trace delay),
// table-driven and random campaigns checked against a GF(2^128) plaintext model.
module tb_aes_trace_sequencer;

    localparam int NT = 4;
    localparam int EN = 51;
    localparam int GP = 15;
    localparam int IW = 16;
    localparam int PERIOD = 1 + EN + GP;
    localparam logic [127:0] SEED = 128'h000000c8_00000000_00000000_00000000;

    logic          AES_clk = 1'b0;
    logic          AES_rst;
    logic          start;
    logic          mode;
    logic [127:0]  fixed_pt;
    logic [127:0]  key_in;
    logic          AES_en;
    logic [127:0]  AES_data_in;
    logic [127:0]  AES_key_in;
    logic [127:0]  AES_data_out = '0;
    logic          AES_data_out_valid = 1'b0;
    logic          trig;
    logic          res_valid;
    logic [127:0]  res_data;
    logic [IW-1:0] res_idx;
    logic          res_fixed;
    logic          busy;
    logic          done;
    logic          timeout_err;

    always #5 AES_clk = ~AES_clk;

    aes_trace_sequencer #(
        .NUM_TRACES(NT), .EN_CYCLES(EN), .GAP_CYCLES(GP), .LFSR_SEED(SEED), .IDX_W(IW)
    ) dut (
        .AES_clk(AES_clk), .AES_rst(AES_rst), .start(start), .mode(mode),
        .fixed_pt(fixed_pt), .key_in(key_in), .AES_en(AES_en),
        .AES_data_in(AES_data_in), .AES_key_in(AES_key_in),
        .AES_data_out(AES_data_out), .AES_data_out_valid(AES_data_out_valid),
        .trig(trig), .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .res_fixed(res_fixed), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // AES stub: dly = clock edges after the first AES_en edge (0 = never answers)
    int   dly_tab [NT];
    bit   dbl_tab [NT];
    int   since = 0;
    int   trno  = -1;
    logic en_d  = 1'b0;

    always @(posedge AES_clk) begin
        en_d               <= AES_en;
        AES_data_out_valid <= 1'b0;
        if (start && !busy)        trno <= -1;
        else if (AES_en && !en_d)  trno <= trno + 1;
        since <= (AES_en && !en_d) ? 1 : since + 1;
        if (trno >= 0 && trno < NT && dly_tab[trno] > 0) begin
            if (since == dly_tab[trno]) begin
                AES_data_out_valid <= 1'b1;
                AES_data_out       <= AES_data_in ^ AES_key_in;
            end else if (dbl_tab[trno] && since == dly_tab[trno] + 5) begin
                AES_data_out_valid <= 1'b1;
                AES_data_out       <= ~(AES_data_in ^ AES_key_in);
            end
        end
    end

    typedef struct {
        int           idx;
        logic [127:0] data;
        bit           fx;
    } res_t;

    res_t         rq[$];
    logic [127:0] ptq[$];
    int           trig_cyc[$];
    int           en_cnt = 0;
    int           cyc = 0;

    always @(posedge AES_clk) cyc <= cyc + 1;

    always @(negedge AES_clk) begin
        res_t r;
        if (start && !busy) begin
            rq.delete();
            ptq.delete();
            trig_cyc.delete();
            en_cnt = 0;
        end
        if (res_valid) begin
            r.idx  = int'(res_idx);
            r.data = res_data;
            r.fx   = res_fixed;
            rq.push_back(r);
        end
        if (trig) begin
            ptq.push_back(AES_data_in);
            trig_cyc.push_back(cyc);
        end
        if (AES_en) en_cnt++;
    end

    typedef struct packed {
        logic                 mode;
        logic [127:0]         key;
        logic [127:0]         fpt;
        logic [NT-1:0][7:0]   dly;
        logic [NT-1:0]        dbl;
        logic                 poke;
        logic                 has_exp;
        logic [7:0]           exp_nres;
        logic                 exp_to;
    } vec_t;

    function automatic vec_t mk(input logic m, input logic [127:0] k, input logic [127:0] f,
                                input logic [NT-1:0][7:0] d, input logic [NT-1:0] db,
                                input logic pk, input logic he, input int en_res, input logic et);
        vec_t v;
        v.mode = m; v.key = k; v.fpt = f; v.dly = d; v.dbl = db; v.poke = pk;
        v.has_exp = he; v.exp_nres = 8'(en_res); v.exp_to = et;
        return v;
    endfunction

    // Multiply by x in GF(2^128) modulo x^128 + x^7 + x^2 + x + 1
    function automatic logic [127:0] mulx(input logic [127:0] v);
        logic [128:0] t;
        t = {v, 1'b0};
        if (t[128]) t = t ^ {1'b1, 120'd0, 8'h87};
        return t[127:0];
    endfunction

    task automatic pulse_start();
        @(posedge AES_clk); #1 start = 1'b1;
        @(posedge AES_clk); #1 start = 1'b0;
    endtask

    task automatic run_campaign(input vec_t v, input string tag);
        logic [127:0] pt_m [NT];
        logic [127:0] lf;
        res_t         exp_q[$];
        res_t         e;
        bit           got_done;
        bit           to_exp;
        bit           fx;
        int           d;
        mode     = v.mode;
        key_in   = v.key;
        fixed_pt = v.fpt;
        for (int i = 0; i < NT; i++) begin
            dly_tab[i] = int'(v.dly[i]);
            dbl_tab[i] = v.dbl[i];
        end
        pulse_start();
        // Scramble the inputs: the campaign must run on the values latched at start
        mode     = ~v.mode;
        key_in   = ~v.key;
        fixed_pt = ~v.fpt;
        got_done = 1'b0;
        for (int c = 0; c < NT * PERIOD + 50; c++) begin
            @(negedge AES_clk);
            if (v.poke) start = (c == 100);
            if (done) begin
                got_done = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk({tag, " done_reached"}, 128'(got_done), 128'd1);
        repeat (3) @(negedge AES_clk);

        lf     = SEED;
        to_exp = 1'b0;
        for (int i = 0; i < NT; i++) begin
            fx      = v.mode && (i % 2 == 0);
            pt_m[i] = fx ? v.fpt : lf;
            if (!fx) lf = mulx(lf);
            d = int'(v.dly[i]);
            if (d >= 1 && d <= 64) begin
                e.idx = i; e.data = pt_m[i] ^ v.key; e.fx = fx;
                exp_q.push_back(e);
            end else begin
                to_exp = 1'b1;
            end
        end

        chk({tag, " trig_count"}, 128'(trig_cyc.size()), 128'(NT));
        for (int i = 0; i < NT && i < ptq.size(); i++)
            chk($sformatf("%s pt%0d", tag, i), ptq[i], pt_m[i]);
        for (int i = 1; i < trig_cyc.size(); i++)
            chk($sformatf("%s trig_gap%0d", tag, i), 128'(trig_cyc[i] - trig_cyc[i-1]), 128'(PERIOD));
        chk({tag, " res_count"}, 128'(rq.size()), 128'(exp_q.size()));
        for (int i = 0; i < rq.size() && i < exp_q.size(); i++) begin
            chk($sformatf("%s res%0d_idx", tag, i), 128'(rq[i].idx), 128'(exp_q[i].idx));
            chk($sformatf("%s res%0d_data", tag, i), rq[i].data, exp_q[i].data);
            chk($sformatf("%s res%0d_fixed", tag, i), 128'(rq[i].fx), 128'(exp_q[i].fx));
        end
        chk({tag, " timeout_err"}, 128'(timeout_err), 128'(to_exp));
        chk({tag, " key_latched"}, AES_key_in, v.key);
        chk({tag, " en_cycles"}, 128'(en_cnt), 128'(NT * EN));
        chk({tag, " busy_end"}, 128'(busy), 128'd0);
        chk({tag, " done_end"}, 128'(done), 128'd1);
        if (v.has_exp) begin
            chk({tag, " tab_nres"}, 128'(rq.size()), 128'(v.exp_nres));
            chk({tag, " tab_to"}, 128'(timeout_err), 128'(v.exp_to));
        end
    endtask

    localparam logic [127:0] KEY0 = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
    localparam logic [127:0] FPT0 = 128'ha6f2daeb_140fa720_529e75d5_21cbc681;

    vec_t         tab [6];
    logic [127:0] saved_pt[$];
    bit           hit;

    initial begin
        tab[0] = mk(1'b0, KEY0, '0,   {8'd10, 8'd10, 8'd10, 8'd10}, 4'b0000, 1'b0, 1'b1, 4, 1'b0);
        tab[1] = mk(1'b1, KEY0, FPT0, {8'd10, 8'd10, 8'd10, 8'd10}, 4'b0000, 1'b0, 1'b1, 4, 1'b0);
        tab[2] = mk(1'b1, KEY0, FPT0, {8'd10, 8'd10, 8'd0,  8'd10}, 4'b0000, 1'b0, 1'b1, 3, 1'b1);
        tab[3] = mk(1'b0, KEY0, '0,   {8'd10, 8'd10, 8'd10, 8'd10}, 4'b0010, 1'b0, 1'b1, 4, 1'b0);
        tab[4] = mk(1'b0, KEY0, '0,   {8'd64, 8'd10, 8'd53, 8'd10}, 4'b0000, 1'b0, 1'b1, 4, 1'b0);
        tab[5] = mk(1'b0, KEY0, '0,   {8'd10, 8'd10, 8'd10, 8'd10}, 4'b0000, 1'b1, 1'b1, 4, 1'b0);

        AES_rst = 1'b1; start = 1'b0; mode = 1'b0; fixed_pt = '0; key_in = '0;
        for (int i = 0; i < NT; i++) begin dly_tab[i] = 0; dbl_tab[i] = 1'b0; end
        #1;
        chk("rst AES_en", 128'(AES_en), 128'd0);
        chk("rst trig", 128'(trig), 128'd0);
        chk("rst res_valid", 128'(res_valid), 128'd0);
        chk("rst busy", 128'(busy), 128'd0);
        chk("rst done", 128'(done), 128'd0);
        chk("rst timeout_err", 128'(timeout_err), 128'd0);
        chk("rst AES_data_in", AES_data_in, 128'd0);
        chk("rst AES_key_in", AES_key_in, 128'd0);
        chk("rst res_data", res_data, 128'd0);
        chk("rst res_idx", 128'(res_idx), 128'd0);
        repeat (3) @(posedge AES_clk);
        #1 AES_rst = 1'b0;
        repeat (4) @(negedge AES_clk);
        chk("idle busy", 128'(busy), 128'd0);
        chk("idle AES_en", 128'(AES_en), 128'd0);

        for (int t = 0; t < 6; t++) begin
            run_campaign(tab[t], $sformatf("tab%0d", t));
            if (t == 0) saved_pt = ptq;
        end
        // tab5 reruns tab0 from DONE with a stray start mid-campaign
        chk("rerun pt_count", 128'(ptq.size()), 128'(saved_pt.size()));
        for (int i = 0; i < ptq.size() && i < saved_pt.size(); i++)
            chk($sformatf("rerun pt%0d", i), ptq[i], saved_pt[i]);

        // Reset during the RUN window of idx 2
        mode = 1'b0; key_in = KEY0; fixed_pt = '0;
        for (int i = 0; i < NT; i++) begin dly_tab[i] = 10; dbl_tab[i] = 1'b0; end
        pulse_start();
        hit = 1'b0;
        for (int c = 0; c < 4 * PERIOD; c++) begin
            @(negedge AES_clk);
            if (trig_cyc.size() == 3) begin hit = 1'b1; break; end
        end
        chk("rstmid reached_idx2", 128'(hit), 128'd1);
        repeat (5) @(negedge AES_clk);
        chk("rstmid en_before", 128'(AES_en), 128'd1);
        #1 AES_rst = 1'b1;
        #1;
        chk("rstmid AES_en", 128'(AES_en), 128'd0);
        chk("rstmid busy", 128'(busy), 128'd0);
        chk("rstmid res_valid", 128'(res_valid), 128'd0);
        @(posedge AES_clk); #1 AES_rst = 1'b0;
        repeat (2) @(negedge AES_clk);
        chk("rstmid idle_busy", 128'(busy), 128'd0);
        chk("rstmid done", 128'(done), 128'd0);
        run_campaign(tab[0], "after_rst");
        if (ptq.size() > 0) chk("after_rst pt0_seed", ptq[0], SEED);
        else                chk("after_rst pt0_present", 128'(ptq.size()), 128'd1);

        for (int r = 0; r < 6; r++) begin
            vec_t v;
            int   k;
            v = mk(1'($urandom % 2), {$urandom, $urandom, $urandom, $urandom},
                   {$urandom, $urandom, $urandom, $urandom}, '0, '0, 1'b0, 1'b0, 0, 1'b0);
            for (int i = 0; i < NT; i++) begin
                k = $urandom % 8;
                if (k == 0)      v.dly[i] = 8'd0;
                else if (k == 1) v.dly[i] = 8'($urandom_range(52, 64));
                else             v.dly[i] = 8'($urandom_range(1, 40));
                v.dbl[i] = (v.dly[i] != 0) && (v.dly[i] <= 59) && ($urandom % 4 == 0);
            end
            run_campaign(v, $sformatf("rnd%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
